// File: rtl/id_ex_skid_pkg.sv
// Shared ALU control codes and the control-code width for the ID/EX boundary.
// Latency: n/a (constants only).
// Backpressure: n/a.
package id_ex_skid_pkg;

    // Width of every ALU_* control code; id_ex_skid's CTRL_W must match it.
    localparam int ALU_CODE_W = 3;

    localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CODE_W-1:0] ALU_MUL = 3'b011;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/id_ex_skid.sv
// ID/EX pipeline boundary: two-entry skid buffer (main + skid register) feeding the ALU.
// Latency: one cycle from in-fire to valid_o; one payload per cycle while ready_i stays high.
// Backpressure: absorbs one extra payload after ready_i drops; ready_o is taken from state only.
//
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (sync squash of held entries)
//   upstream  : valid_i, ready_o, data1_i, data2_i, ALUCtrl_i, RdAddr_i, RegWrite_i
//   downstream: valid_o, ready_i, data1_o, data2_o, ALUCtrl_o, RdAddr_o, RegWrite_o
module id_ex_skid
    import id_ex_skid_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = id_ex_skid_pkg::ALU_CODE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,

    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [CTRL_W-1:0] ALUCtrl_i,
    input  logic [4:0]        RdAddr_i,
    input  logic              RegWrite_i,

    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic [4:0]        RdAddr_o,
    output logic              RegWrite_o
);

    typedef struct packed {
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [CTRL_W-1:0] alu_ctrl;
        logic [4:0]        rd_addr;
        logic              reg_write;
    } payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t   state;
    payload_t main_q;
    payload_t skid_q;
    payload_t in_dat;
    logic     in_fire;
    logic     out_fire;

    assign in_dat = '{data1:     data1_i,
                      data2:     data2_i,
                      alu_ctrl:  ALUCtrl_i,
                      rd_addr:   RdAddr_i,
                      reg_write: RegWrite_i};

    // Both handshake flags come straight from the state register, so neither
    // ready_o nor valid_o has a combinational path from the other side.
    assign valid_o  = (state != EMPTY);
    assign ready_o  = (state != FULL);
    assign in_fire  = valid_i && ready_o;
    assign out_fire = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            // Payload registers keep their contents; only validity is squashed.
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_dat;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_dat;
                    end else if (in_fire) begin
                        // Main is stalled, so the newer payload parks behind it.
                        skid_q <= in_dat;
                        state  <= FULL;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign data1_o    = main_q.data1;
    assign data2_o    = main_q.data2;
    assign ALUCtrl_o  = main_q.alu_ctrl;
    assign RdAddr_o   = main_q.rd_addr;
    // A bubble must never write the register file even if main holds stale data.
    assign RegWrite_o = main_q.reg_write && valid_o;

endmodule
